// File: rtl/button_debouncer_pkg.sv
// ============================================================================
// Module      : button_debouncer_pkg
// Description : Shared state encodings for the button debouncer family.
//               The 2-bit values are fixed so that multi-button wrappers can
//               decode a debouncer state without knowing its internals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_debouncer_pkg;

   // Debouncer FSM states; encodings are part of the shared contract.
   typedef enum logic [1:0] {
      ST_IDLE_LOW  = 2'd0,
      ST_WAIT_HIGH = 2'd1,
      ST_IDLE_HIGH = 2'd2,
      ST_WAIT_LOW  = 2'd3
   } state_e;

endpackage : button_debouncer_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input bit.
//               No logic sits between the two flops so the first stage has
//               a full clock period to resolve metastability.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   // Shift the asynchronous input through two flops; async clear to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Turns a raw bouncing button level into a clean registered
//               level plus single-cycle rise/fall strobes. A new level is
//               accepted only after STABLE_CYCLES consecutive identical
//               synchronized samples; any shorter excursion is discarded.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   // Counter is sized from STABLE_CYCLES and must not be set independently.
   localparam int                    CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

   logic                 btn_sync;
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic                 busy_q, busy_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (btn_in),
      .q_o   (btn_sync)
   );

   // Qualification FSM: decide next state, counter and output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         ST_IDLE_LOW: begin
            if (btn_sync) begin
               state_d = ST_WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         ST_WAIT_HIGH: begin
            if (!btn_sync) begin
               // Bounce: drop the candidate, count restarts on next excursion.
               state_d = ST_IDLE_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_IDLE_HIGH: begin
            if (!btn_sync) begin
               state_d = ST_WAIT_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         ST_WAIT_LOW: begin
            if (btn_sync) begin
               state_d = ST_IDLE_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE_LOW;
         end
      endcase
      busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
   end

   // State, counter and all outputs registered together; async clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

endmodule : button_debouncer

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer with STABLE_CYCLES=4.
//               Expected strobes (edge number and direction) are queued when
//               stimulus is applied and matched when the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;
   import button_debouncer_pkg::*;

   localparam int STABLE = 4;
   localparam int LAT    = STABLE + 2;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_in;
   logic level_out, rise_pulse, fall_pulse, busy;
   logic inv_out;

   typedef struct {
      int edge_no;
      bit is_rise;
   } ev_t;

   ev_t sb[$];
   int  cyc    = 0;
   int  checks = 0;
   int  errors = 0;

   button_debouncer #(.STABLE_CYCLES(STABLE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_in     (btn_in),
      .level_out  (level_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy)
   );

   // Downstream inverter stage.
   assign inv_out = ~level_out;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every strobe must match the oldest queued event.
   always @(negedge clk) begin
      if (rst_n && (rise_pulse || fall_pulse)) begin
         checks++;
         if (rise_pulse && fall_pulse) begin
            errors++;
            $display("FAIL both_pulses edge=%0d got rise=1 fall=1 want at most one", cyc);
         end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse edge=%0d rise=%0b fall=%0b want none", cyc, rise_pulse, fall_pulse);
         end else begin
            ev_t e;
            e = sb.pop_front();
            if (e.edge_no !== cyc || e.is_rise !== rise_pulse) begin
               errors++;
               $display("FAIL pulse_match got edge=%0d rise=%0b want edge=%0d rise=%0b",
                        cyc, rise_pulse, e.edge_no, e.is_rise);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n  = 1'b0;
      btn_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         btn_in = ~btn_in;
         checks++;
         if ({level_out, rise_pulse, fall_pulse, busy} !== 4'b0000 || dut.state_q !== ST_IDLE_LOW) begin
            errors++;
            $display("FAIL reset_hold got outs=%b state=%0d want outs=0000 state=0",
                     {level_out, rise_pulse, fall_pulse, busy}, dut.state_q);
         end
      end
      @(negedge clk);
      btn_in = 1'b0;
      rst_n  = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({level_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle got outs=%b want 0000", {level_out, rise_pulse, fall_pulse, busy});
      end
   endtask

   // Hold a new level and watch level/strobes for each edge after the change.
   task automatic test_level_change(input bit to_high, input string name);
      @(negedge clk);
      btn_in = to_high;
      sb.push_back('{edge_no: cyc + LAT, is_rise: to_high});
      for (int k = 1; k <= LAT + 3; k++) begin
         @(negedge clk);
         checks++;
         if (level_out !== ((k >= LAT) ? to_high : !to_high) || inv_out !== ~level_out ||
             rise_pulse !== (to_high && k == LAT) || fall_pulse !== (!to_high && k == LAT)) begin
            errors++;
            $display("FAIL %s k=%0d got lvl=%b inv=%b r=%b f=%b want lvl=%b inv=%b r=%b f=%b",
                     name, k, level_out, inv_out, rise_pulse, fall_pulse,
                     (k >= LAT) ? to_high : !to_high, (k >= LAT) ? !to_high : to_high,
                     to_high && k == LAT, !to_high && k == LAT);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      btn_in = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 3) btn_in = 1'b0;
         checks++;
         if (busy !== (k >= 3 && k <= 5) || level_out !== 1'b0) begin
            errors++;
            $display("FAIL glitch k=%0d got busy=%b lvl=%b want busy=%b lvl=0",
                     k, busy, level_out, (k >= 3 && k <= 5));
         end
      end
   endtask

   task automatic test_bounce();
      bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         btn_in = pat[i];
      end
      test_level_change(1'b1, "bounce_settle");
   endtask

   task automatic test_midop_reset();
      // Start from a clean low state.
      @(negedge clk);
      btn_in = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      btn_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midop_busy got %b want 1", busy);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({level_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL midop_async_clear got %b want 0000", {level_out, rise_pulse, fall_pulse, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back('{edge_no: cyc + LAT, is_rise: 1'b1});
      for (int k = 1; k <= LAT + 2; k++) begin
         @(negedge clk);
         checks++;
         if (level_out !== (k >= LAT) || rise_pulse !== (k == LAT)) begin
            errors++;
            $display("FAIL midop_rise k=%0d got lvl=%b r=%b want lvl=%b r=%b",
                     k, level_out, rise_pulse, k >= LAT, k == LAT);
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL midop_drain got %0d pending want 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_level_change(1'b1, "clean_press");
      test_level_change(1'b0, "release");
      test_glitch();
      test_bounce();
      test_midop_reset();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_button_debouncer

`default_nettype wire
